// File: rtl/tern_pkg.sv
// Shared types and field positions for the ternary MAC phase sequencer and its loader.
// Latency: none (declarations only).
// Backpressure: n/a.
package tern_pkg;

  // Size limits of the ternary MAC array
  localparam int MAX_IN_LEN  = 16;
  localparam int MAX_OUT_LEN = 8;

  // cfg_param layout: {in_len-1, out_len-1}
  localparam int CFG_W       = 7;
  localparam int CFG_IN_MSB  = 6;
  localparam int CFG_IN_LSB  = 3;
  localparam int CFG_OUT_MSB = 2;
  localparam int CFG_OUT_LSB = 0;

  // Sticky error flag positions
  localparam int ERR_ABORT = 0;
  localparam int ERR_NOWGT = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_READY  = 3'd3,
    S_RUN    = 3'd4,
    S_MAC    = 3'd5,
    S_SERIAL = 3'd6
  } state_t;

endpackage

// File: rtl/tern_seq_ctrl.sv
// Phase sequencer: weight load window (2 cycles/column) + settle, then accept/MAC/serialise per vector.
// Latency: vector handshake at edge t -> mac_en in cycle t+1 -> first output beat in cycle t+2.
// Backpressure: in_valid/in_ready on input, out_valid/out_ready per column; ena=0 freezes (aborts in LOAD).
module tern_seq_ctrl
  import tern_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [CFG_W-1:0]              cfg_param,
  input  logic                          start_load,
  input  logic                          start_run,
  input  logic                          stop,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          load_ena,
  output logic [CFG_W-1:0]              load_param,
  output logic                          weights_valid,
  output logic                          mac_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(MAX_OUT_LEN)-1:0] out_sel,
  output logic                          out_last,
  output logic                          busy,
  output logic [1:0]                    err,
  output logic [2:0]                    state_o
);

  localparam int OB  = $clog2(MAX_OUT_LEN);
  localparam int LCW = $clog2(2 * MAX_OUT_LEN);

  state_t          state;
  logic [LCW-1:0]  load_cnt;
  logic [OB-1:0]   out_idx;
  logic            stop_pending;

  logic [OB-1:0]   n_m1;       // out_len-1 from the latched config
  logic [LCW-1:0]  load_last;  // 2N-1: final cycle of the load window
  logic            in_hs;
  logic            out_hs;
  logic            beat_last;

  assign n_m1      = OB'(load_param[CFG_OUT_MSB:CFG_OUT_LSB]);
  assign load_last = LCW'({n_m1, 1'b1});
  assign beat_last = (out_idx == n_m1);

  // Strobes are qualified by ena so a deselected block shows no activity.
  assign load_ena      = (state == S_LOAD) && ena;
  assign in_ready      = (state == S_RUN) && ena;
  assign mac_en        = (state == S_MAC) && ena;
  assign out_valid     = (state == S_SERIAL) && ena;
  assign out_sel       = (state == S_SERIAL) ? out_idx : '0;
  assign out_last      = (state == S_SERIAL) && beat_last;
  assign weights_valid = (state == S_READY) || (state == S_RUN) ||
                         (state == S_MAC)   || (state == S_SERIAL);
  assign busy          = (state != S_IDLE) && (state != S_READY);
  assign state_o       = state;

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  // Phase FSM with the load-window and output-column counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      load_param   <= '0;
      load_cnt     <= '0;
      out_idx      <= '0;
      stop_pending <= 1'b0;
      err          <= 2'b00;
    end else begin
      // A stop arriving while a vector is in flight is remembered even when frozen.
      if (((state == S_MAC) || (state == S_SERIAL)) && stop)
        stop_pending <= 1'b1;

      case (state)
        S_IDLE: begin
          if (ena) begin
            if (start_load) begin
              load_param <= cfg_param;
              load_cnt   <= '0;
              state      <= S_LOAD;
            end else if (start_run) begin
              err[ERR_NOWGT] <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (!ena) begin
            // Loader restarts at column 0 on re-enable, so the partial load is void.
            err[ERR_ABORT] <= 1'b1;
            load_cnt       <= '0;
            state          <= S_IDLE;
          end else if (load_cnt == load_last) begin
            state <= S_SETTLE;
          end else begin
            load_cnt <= load_cnt + 1'b1;
          end
        end

        S_SETTLE: begin
          if (ena)
            state <= S_READY;
        end

        S_READY: begin
          if (ena) begin
            if (start_load) begin
              load_param <= cfg_param;
              load_cnt   <= '0;
              state      <= S_LOAD;
            end else if (start_run) begin
              state <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (in_hs) begin
            if (stop)
              stop_pending <= 1'b1;
            state <= S_MAC;
          end else if (ena && stop) begin
            state <= S_READY;
          end
        end

        S_MAC: begin
          if (ena) begin
            out_idx <= '0;
            state   <= S_SERIAL;
          end
        end

        S_SERIAL: begin
          if (out_hs) begin
            if (beat_last) begin
              out_idx <= '0;
              if (stop_pending || stop) begin
                stop_pending <= 1'b0;
                state        <= S_READY;
              end else begin
                state <= S_RUN;
              end
            end else begin
              out_idx <= out_idx + 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tern_seq_ctrl.sv
// Self-checking bench for tern_seq_ctrl: directed phases plus randomized configs and out_ready patterns.
// Expectations come from transaction-level rules: 2N load cycles, N beats per vector, fixed latencies.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_tern_seq_ctrl;
  import tern_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [6:0] cfg_param = 7'h00;
  logic       start_load = 1'b0;
  logic       start_run = 1'b0;
  logic       stop = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, load_ena, weights_valid, mac_en, out_valid, out_last, busy;
  logic [6:0] load_param;
  logic [2:0] out_sel;
  logic [1:0] err;
  logic [2:0] state_o;

  int         errors = 0;
  int         checks = 0;
  logic [1:0] exp_err = 2'b00;

  always #5 clk = ~clk;

  tern_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_param(cfg_param),
    .start_load(start_load), .start_run(start_run), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .load_ena(load_ena),
    .load_param(load_param), .weights_valid(weights_valid), .mac_en(mac_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
    .out_last(out_last), .busy(busy), .err(err), .state_o(state_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load with cfg; expect load_ena for cycles 1..2N and weights_valid first at 2N+2, ending in READY.
  task automatic do_load(input logic [6:0] cfg, input logic with_run);
    int n, cnt, first_le, last_le, first_wv;
    n = int'(cfg[2:0]) + 1;
    cfg_param  = cfg;
    start_load = 1'b1;
    start_run  = with_run;
    step();
    start_load = 1'b0;
    start_run  = 1'b0;
    cfg_param  = ~cfg;
    cnt = 0; first_le = -1; last_le = -1; first_wv = -1;
    for (int i = 1; i <= 40 && first_wv < 0; i++) begin
      if (load_ena) begin
        cnt++;
        if (first_le < 0) first_le = i;
        last_le = i;
      end
      if (weights_valid) first_wv = i;
      if (first_wv < 0) step();
    end
    chk("load_cycles", cnt, 2 * n);
    chk("load_first", first_le, 1);
    chk("load_lastcyc", last_le, 2 * n);
    chk("wv_first", first_wv, 2 * n + 2);
    chk("load_param", load_param, cfg);
    chk("load_err", err, exp_err);
    chk("load_end_inr", in_ready, 0);
    chk("load_end_state", state_o, S_READY);
  endtask

  // One vector from READY. mode: 0 ready, 1 stall 3 at col 1, 2 random ready, 3 ena low 2 cycles at col 1.
  // stop_idx: -1 none, -2 with the input handshake, k>=0 during column k.
  task automatic run_vec(input int n, input int mode, input int stop_idx);
    int   idx, stalls, frz, t;
    logic go, stop_sent, exp_ready_end;
    start_run = 1'b1;
    step();
    start_run = 1'b0;
    chk("run_in_ready", in_ready, 1);
    chk("run_wv", weights_valid, 1);
    in_valid = 1'b1;
    stop     = (stop_idx == -2);
    step();
    in_valid = 1'b0;
    stop     = 1'b0;
    chk("mac_en", mac_en, 1);
    chk("mac_out_valid", out_valid, 0);
    chk("mac_in_ready", in_ready, 0);
    step();
    idx = 0; stalls = 0; frz = 0; t = 0; stop_sent = 1'b0;
    while (idx < n && t < 100) begin
      chk("ser_valid", out_valid, ena);
      chk("ser_sel", out_sel, idx);
      chk("ser_last", out_last, idx == n - 1);
      chk("ser_mac", mac_en, 0);
      stop = (idx == stop_idx) && !stop_sent;
      if (stop) stop_sent = 1'b1;
      ena = 1'b1;
      out_ready = 1'b1;
      case (mode)
        1: if (idx == 1 && stalls < 3) begin out_ready = 1'b0; stalls++; end
        2: out_ready = 1'($urandom_range(0, 1));
        3: if (idx == 1 && frz < 2) begin ena = 1'b0; frz++; end
        default: ;
      endcase
      go = ena && out_ready;
      step();
      stop = 1'b0;
      if (go) idx++;
      t++;
    end
    ena = 1'b1;
    out_ready = 1'b0;
    chk("ser_beats", idx, n);
    if (mode == 0) chk("ser_cycles", t, n);
    exp_ready_end = (stop_idx != -1) && (stop_idx < n);
    chk("end_out_valid", out_valid, 0);
    chk("end_state", state_o, exp_ready_end ? S_READY : S_RUN);
    chk("end_in_ready", in_ready, !exp_ready_end);
    if (!exp_ready_end) begin
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("stop_run_state", state_o, S_READY);
    end
  endtask

  initial begin
    logic [6:0] cfg;
    int         n;

    // Reset state
    step();
    step();
    chk("rst_state", state_o, S_IDLE);
    chk("rst_load_param", load_param, 0);
    chk("rst_err", err, 0);
    chk("rst_load_ena", load_ena, 0);
    chk("rst_wv", weights_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    ena   = 1'b1;
    step();

    // Abort a load at load_cnt=5 (N=4)
    cfg_param  = 7'h5B;
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    repeat (5) step();
    chk("abort_pre_le", load_ena, 1);
    ena = 1'b0;
    step();
    ena = 1'b1;
    exp_err[ERR_ABORT] = 1'b1;
    chk("abort_state", state_o, S_IDLE);
    chk("abort_err", err, 2'b01);
    chk("abort_le", load_ena, 0);
    chk("abort_wv", weights_valid, 0);
    do_load(7'h5B, 1'b0);

    // Latency with N=4, out_ready tied high
    run_vec(4, 0, -1);

    // Reset in the middle of serialisation
    start_run = 1'b1;
    step();
    start_run = 1'b0;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    step();
    out_ready = 1'b1;
    rst_n     = 1'b0;
    step();
    rst_n     = 1'b1;
    out_ready = 1'b0;
    exp_err   = 2'b00;
    chk("mrst_state", state_o, S_IDLE);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_load_param", load_param, 0);
    chk("mrst_err", err, 0);
    chk("mrst_wv", weights_valid, 0);

    // Deselected IDLE ignores requests; selected start_run without weights flags an error
    ena = 1'b0;
    start_run = 1'b1;
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    chk("noena_state", state_o, S_IDLE);
    chk("noena_err", err, 0);
    ena = 1'b1;
    step();
    start_run = 1'b0;
    exp_err[ERR_NOWGT] = 1'b1;
    chk("nowgt_err", err, 2'b10);
    chk("nowgt_state", state_o, S_IDLE);

    // Load boundaries: widest and narrowest output lengths
    do_load(7'h3F, 1'b0);
    run_vec(8, 0, -1);
    do_load(7'h00, 1'b0);
    run_vec(1, 0, -1);
    run_vec(1, 0, 0);

    // start_load wins over start_run in READY; then the directed vector cases
    cfg = {4'($urandom_range(0, 15)), 3'd3};
    do_load(cfg, 1'b1);
    run_vec(4, 1, -1);
    run_vec(4, 0, 1);
    run_vec(4, 0, -2);
    run_vec(4, 3, -1);

    // Randomized configurations and vector traffic
    for (int r = 0; r < 6; r++) begin
      cfg = 7'($urandom_range(0, 127));
      n   = int'(cfg[2:0]) + 1;
      do_load(cfg, 1'($urandom_range(0, 1)));
      for (int v = 0; v < 3; v++)
        run_vec(n, int'($urandom_range(0, 3)), int'($urandom_range(0, n + 1)) - 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tern_seq_ctrl.md
Name: tern_seq_ctrl

Overview:
Phase sequencer for the ternary MAC accelerator. It drives the weight loader's enable for exactly the two-cycles-per-column load window and inserts the one-cycle weight settle. It then runs the compute phase: it accepts input vectors over a valid/ready handshake, fires the MAC array, and serialises one output column per beat to the output mux. It sits between the top-level pin decoder and the loader/MAC datapath.

Parameters:
MAX_IN_LEN, 16, max input-vector length; cfg_param[6:3] holds in_len-1.
MAX_OUT_LEN, 8, max output columns; cfg_param[2:0] holds out_len-1; OB = $clog2(MAX_OUT_LEN).

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
ena  input  1  design selected; low freezes or aborts (see Behaviour)
cfg_param  input  7  {in_len-1, out_len-1}; sampled only when start_load is accepted
start_load  input  1  level, sampled per cycle; request a weight (re)load
start_run  input  1  request entry to compute phase
stop  input  1  request return to READY
in_valid  input  1  input vector present on datapath pins
in_ready  output  1  vector accepted when in_valid & in_ready
load_ena  output  1  enable to weight loader
load_param  output  7  latched cfg, stable from LOAD through RUN
weights_valid  output  1  loaded weights usable
mac_en  output  1  one-cycle pulse: MAC array captures vector
out_valid  output  1  output beat present
out_ready  input  1  consumer takes beat
out_sel  output  OB  column index of current beat
out_last  output  1  final column of vector
busy  output  1  state not IDLE/READY
err  output  2  sticky: [0] load aborted, [1] run without weights
state_o  output  3  FSM state for debug

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, load_param=0, all counters=0, err=0, stop_pending=0. All outputs 0.
- FSM: IDLE, LOAD, SETTLE, READY, RUN, MAC, SERIAL. Encoding is in the package.
- N = load_param[2:0]+1.
- IDLE:
  - start_load & ena -> latch cfg_param into load_param, clear load_cnt, go to LOAD.
  - start_run & ena without start_load -> set err[1], stay in IDLE.
- LOAD:
  - load_ena=1 for exactly 2N consecutive cycles; load_cnt counts 0..2N-1.
  - At load_cnt==2N-1 -> SETTLE.
  - load_ena is 0 in all other states, so the loader always sees a rising edge at load start.
- SETTLE: one cycle, load_ena=0 -> READY.
- READY:
  - weights_valid=1.
  - start_load -> LOAD (re-latch cfg, weights_valid drops next cycle).
  - start_run -> RUN.
  - start_load beats start_run when both are high; the same holds in IDLE.
- RUN:
  - weights_valid=1; in_ready=ena.
  - Handshake -> MAC.
  - stop with no handshake in the same cycle -> READY.
  - stop together with a handshake -> set stop_pending, go to MAC.
- MAC: mac_en=1 for exactly one cycle; out_idx=0 -> SERIAL.
- SERIAL:
  - out_valid=1, out_sel=out_idx, out_last=(out_idx==N-1).
  - out_idx advances only on out_valid & out_ready.
  - Last beat accepted -> READY if stop_pending (then clear it), else RUN.
  - stop seen in MAC or SERIAL sets stop_pending.
- start_load and start_run are ignored in LOAD, SETTLE, RUN, MAC and SERIAL.
- Latency: handshake at edge t -> mac_en high in cycle t+1 -> first out_valid in cycle t+2. Minimum vector period is N+2 cycles with out_ready tied high.
- ena=0:
  - In LOAD: abort to IDLE next edge, set err[0], weights_valid=0. The loader would otherwise restart at column 0 on ena re-rise.
  - In any other state: state and counters hold; in_ready, out_valid and mac_en are forced to 0; stop_pending still captures stop.
- Reset mid-operation: immediate return to the reset state on the next edge. No beat is completed.
- in_len (load_param[6:3]) is passed through only; the controller does not count on it.
- Widths:
  - load_cnt is $clog2(2*MAX_OUT_LEN) bits; 2N never wraps.
  - out_idx is OB bits; N-1 compare is done at OB width.

Decomposition:
- Package tern_pkg holds:
  - the state typedef (3-bit enum);
  - the field localparams CFG_IN_MSB=6, CFG_IN_LSB=3, CFG_OUT_MSB=2, CFG_OUT_LSB=0;
  - the err bit indices ERR_ABORT=0 and ERR_NOWGT=1.
- The package is shared with the loader and the top level.
- No sub-module: a single FSM with two counters (load_cnt, out_idx) fits in one module.

Test Plan:
- cfg_param=7'h3F, start_load pulse at cycle 0 -> load_ena high cycles 1..16, SETTLE at 17, weights_valid=1 from 18, load_param=7'h3F.
- cfg_param=7'h00 (N=1) -> load_ena high cycles 1..2 only, weights_valid from 4.
- READY, N=4, start_run, in_valid at cycle c, out_ready=1 -> mac_en at c+1, out_sel 0,1,2,3 at c+2..c+5, out_last only at c+5, in_ready again at c+6.
- Same, out_ready low for 3 cycles at out_sel=1 -> out_sel holds 1 with out_valid high, no skipped or duplicated index.
- ena dropped at load_cnt=5 -> IDLE next edge, err=2'b01, load_ena=0, weights_valid=0; subsequent start_load performs a full 2N load.
- start_run in IDLE -> err[1]=1, state stays IDLE.
- stop during SERIAL at out_sel=1 -> remaining beats complete, then READY, no in_ready.
